fifo_uart_tx: RTL
=================

# fifo_uart_tx

Serial transmitter that drains the 16×8 FIFO and sends each byte as an 8N1 UART frame on a single `tx` line. It sits directly downstream of the FIFO: it watches the FIFO's `empty`, pulses the FIFO's `ren`, and captures the registered `rdata` one cycle later. Bytes leave LSB first at a rate of `CLKS_PER_BIT` clocks per bit.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `clk`  input  1  system clock, rising-edge active.
- `reset`  input  1  asynchronous, active-low reset.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_rdata`  input  8  FIFO `rdata`; valid in the cycle after `fifo_ren` is high.
- `fifo_ren`  output  1  FIFO read enable; a single-cycle pulse per byte.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  high whenever the FSM is outside IDLE.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, DATA, (PARITY), STOP.
- IDLE: if `fifo_empty`=0 at a clock edge, go to FETCH. Otherwise stay.
- FETCH: `fifo_ren`=1 for exactly this one cycle, then go to LOAD. `fifo_ren` is never asserted while `fifo_empty`=1.
- LOAD: latch `fifo_rdata` into an 8-bit shift register, clear the bit index, go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, shifting right after each bit. After bit index 7 completes, go to PARITY if that feature is compiled in, otherwise to STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Back-to-back bytes: if the FIFO is still non-empty on return to IDLE, the next FETCH follows immediately.
- Baud counter:
  - width is `$clog2(CLKS_PER_BIT)`, minimum 1.
  - cleared on every state entry.
  - it counts 0..`CLKS_PER_BIT`-1; the bit ends when the count reaches terminal.
- Reset mid-frame:
  - the FSM goes to IDLE, `tx`=1, `fifo_ren`=0 and the counters clear, all immediately (asynchronous).
  - any byte already popped from the FIFO is discarded; the FIFO is not rewound.
- FIFO writes happening at the same time as a FETCH are the FIFO's concern. This block reacts only to `fifo_empty` as sampled in IDLE.

## Timing
- Reset values: `tx`=1, `fifo_ren`=0, `busy`=0, FSM=IDLE.
- `tx`, `fifo_ren` and `busy` are all registered outputs.
- Latency: the `tx` falling edge (start bit) appears 3 clock edges after the edge at which IDLE sees `fifo_empty`=0 (IDLE→FETCH, FETCH→LOAD, LOAD→START).
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- Byte-to-byte period with a non-empty FIFO: 3 + 10×`CLKS_PER_BIT` cycles (3 + 11×`CLKS_PER_BIT` with parity).
- `busy` rises one cycle after the IDLE→FETCH decision edge and falls one cycle after STOP completes.

## Configuration
- Macro: `FIFO_UART_TX_PARITY_EN`.
- Defined: the PARITY state is compiled in. It sends an even-parity bit (XOR of the 8 data bits, so 0x2D sends 0) for `CLKS_PER_BIT` cycles between DATA and STOP. The frame becomes 8E1.
- Undefined: the PARITY state and its logic are absent. The frame is 8N1 and DATA goes directly to STOP.

## Structure
- Package `uart_pkg`:
  - state enum `uart_tx_state_t`.
  - `UART_DATA_BITS`=8.
  - idle line level constant `UART_IDLE`=1'b1.
- Sub-module `uart_baud_tick`:
  - parameterised by `CLKS_PER_BIT`.
  - inputs `clk`, `reset`, `clear`.
  - output `tick`, pulsing in the last cycle of each bit period.
  - the FSM advances on `tick`.

## Test plan
Bench parameters: `CLKS_PER_BIT`=4, driving the real FIFO.
- Reset hold:
  - stimulus: hold `reset`=0 for 5 cycles with `fifo_empty`=0.
  - response: `tx`=1, `fifo_ren`=0 and `busy`=0 throughout; no read occurs.
- Single byte:
  - stimulus: write 0x2D.
  - response: `fifo_ren` pulses once; `tx` falls 3 edges after `empty` drops.
  - serial line reads 0,1,0,1,1,0,1,0,0,1, each bit held 4 cycles; `busy` falls after 40 frame cycles.
- Burst:
  - stimulus: write 45,46,47 back-to-back.
  - response: three frames whose start bits are 43 cycles apart; bytes decode as 45,46,47 in order; exactly 3 `fifo_ren` pulses.
- Empty guard:
  - stimulus: drain the FIFO, then idle 50 cycles.
  - response: `fifo_ren` stays 0 and `tx` stays 1.
- Mid-frame reset:
  - stimulus: assert `reset` during DATA bit 3 of byte 0xA5.
  - response: `tx`=1 within the same cycle, with no partial stop bit.
  - after release, the next byte written (0x3C) is sent correctly.
- Parity build:
  - stimulus: with `FIFO_UART_TX_PARITY_EN` defined, send 0x07.
  - response: parity bit = 1, frame length 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the state enum.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP  = 3'd6
  } uart_tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between the 16x8 FIFO (slave) and the transmitter (master).
interface fifo_uart_tx_if
  import uart_pkg::*;
;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_ren;

  modport master (input fifo_empty, input fifo_rdata, output fifo_ren);
  modport slave  (output fifo_empty, output fifo_rdata, input fifo_ren);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  // A state change restarts the period so every state gets a full bit time.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the upstream FIFO one byte at a time and sends each as an 8N1 frame on tx.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  fifo_uart_tx_if.master  fifo,
  output logic            tx,
  output logic            busy
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic                      tx_q, tx_d;
  logic                      ren_q, ren_d;
  logic                      busy_q, busy_d;
  logic                      tick;
  logic                      baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (tick)
  );

  assign baud_clear    = (state_d != state_q);
  assign fifo.fifo_ren = ren_q;
  assign tx            = tx_q;
  assign busy          = busy_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo.fifo_empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d   = fifo.fifo_rdata;
        bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = ^fifo.fifo_rdata;
`endif
        state_d   = ST_START;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    ren_d  = (state_d == ST_FETCH);
    busy_d = (state_d != ST_IDLE);
    tx_d   = UART_IDLE;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      tx_q      <= UART_IDLE;
      ren_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ren_q     <= ren_d;
      busy_q    <= busy_d;
    end
  end

  // Payload registers are always reloaded in LOAD before use, so they carry no reset.
  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

endmodule
